// File: rtl/sram_word_ctrl_if.sv
// CPU-side PicoRV32 native memory bus bundle.
// master: CPU drives valid/addr/wdata/wstrb; slave: controller returns ready/rdata.
interface sram_word_ctrl_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );
    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sram_word_ctrl.sv
// 32-bit PicoRV32 bus to 256K x 16 async SRAM bridge; lo/hi halfword cycles, RMW for partial writes.
// Ports: clk, rst (sync, active-high), bus (slave side of CPU bus), sram_* pins (SA/SD/CS_N/OE_N/WE_N).
module sram_word_ctrl #(
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_word_ctrl_if.slave        bus,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [15:0]            sram_data_in,
    output logic [15:0]            sram_data_out,
    output logic                   sram_data_oe,
    output logic                   sram_cs_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);
    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] base_q, base_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]            sram_data_out_q, sram_data_out_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [31:0]            mem_rdata_q, mem_rdata_d;

    logic                   start, start_hi, hi_skip;
    logic [SRAM_ADDR_W-1:0] st_base;
    logic [31:0]            st_wdata;
    logic [3:0]             st_wstrb;
    logic [1:0]             lane_s, start_s;
    logic [15:0]            lane_w, merged;

    logic unused_addr;
    assign unused_addr = ^{bus.mem_addr[31:SRAM_ADDR_W+1], bus.mem_addr[1:0]};

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        cnt_d           = cnt_q;
        base_d          = base_q;
        sram_addr_d     = sram_addr_q;
        sram_data_out_d = sram_data_out_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        mem_rdata_d     = mem_rdata_q;
        start           = 1'b0;
        start_hi        = 1'b0;
        st_base         = base_q;
        st_wdata        = wdata_q;
        st_wstrb        = wstrb_q;
        lane_s          = phase_q ? wstrb_q[3:2] : wstrb_q[1:0];
        lane_w          = phase_q ? wdata_q[31:16] : wdata_q[15:0];
        // strobed bytes from the CPU win over the value just read back
        merged = {lane_s[1] ? lane_w[15:8] : sram_data_in[15:8],
                  lane_s[0] ? lane_w[7:0]  : sram_data_in[7:0]};
        // a write with no hi-lane strobes needs no hi SRAM cycle
        hi_skip = (wstrb_q != 4'b0000) && (wstrb_q[3:2] == 2'b00);

        unique case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    st_base  = {bus.mem_addr[SRAM_ADDR_W:2], 1'b0};
                    st_wdata = bus.mem_wdata;
                    st_wstrb = bus.mem_wstrb;
                    base_d   = st_base;
                    wdata_d  = st_wdata;
                    wstrb_d  = st_wstrb;
                    start    = 1'b1;
                    start_hi = (bus.mem_wstrb != 4'b0000) &&
                               (bus.mem_wstrb[1:0] == 2'b00);
                end
            end
            RD: begin
                if (cnt_q == LAST) begin
                    if (wstrb_q == 4'b0000) begin
                        if (phase_q) begin
                            mem_rdata_d[31:16] = sram_data_in;
                            state_d = DONE;
                        end else begin
                            mem_rdata_d[15:0] = sram_data_in;
                            start    = 1'b1;
                            start_hi = 1'b1;
                        end
                    end else begin
                        sram_data_out_d = merged;
                        state_d = WR_SETUP;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = 4'd0;
            end
            WR_PULSE: begin
                if (cnt_q == LAST) state_d = WR_HOLD;
                else cnt_d = cnt_q + 4'd1;
            end
            WR_HOLD: begin
                if (phase_q || hi_skip) begin
                    state_d = DONE;
                end else begin
                    start    = 1'b1;
                    start_hi = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // shared entry into a halfword phase
        start_s = start_hi ? st_wstrb[3:2] : st_wstrb[1:0];
        if (start) begin
            phase_d     = start_hi;
            cnt_d       = 4'd0;
            sram_addr_d = st_base | SRAM_ADDR_W'(start_hi);
            if (start_s == 2'b11) begin
                state_d = WR_SETUP;
                sram_data_out_d = start_hi ? st_wdata[31:16] : st_wdata[15:0];
            end else begin
                state_d = RD;
            end
        end
    end

    always_comb begin
        sram_cs_n     = 1'b1;
        sram_oe_n     = 1'b1;
        sram_we_n     = 1'b1;
        sram_data_oe  = 1'b0;
        bus.mem_ready = 1'b0;
        unique case (state_q)
            RD: begin
                sram_cs_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                sram_cs_n    = 1'b0;
                sram_data_oe = 1'b1;
            end
            WR_PULSE: begin
                sram_cs_n    = 1'b0;
                sram_we_n    = 1'b0;
                sram_data_oe = 1'b1;
            end
            DONE: bus.mem_ready = 1'b1;
            default: ;
        endcase
    end

    assign sram_addr     = sram_addr_q;
    assign sram_data_out = sram_data_out_q;
    assign bus.mem_rdata = mem_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            phase_q         <= 1'b0;
            cnt_q           <= 4'd0;
            base_q          <= '0;
            sram_addr_q     <= '0;
            sram_data_out_q <= 16'h0000;
            wdata_q         <= 32'h0;
            wstrb_q         <= 4'h0;
            mem_rdata_q     <= 32'h0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            cnt_q           <= cnt_d;
            base_q          <= base_d;
            sram_addr_q     <= sram_addr_d;
            sram_data_out_q <= sram_data_out_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            mem_rdata_q     <= mem_rdata_d;
        end
    end
endmodule

// File: tb/tb_sram_word_ctrl.sv
// Testbench for sram_word_ctrl: async SRAM model, word-level reference memory, directed + random txns.
// Ports: none (top-level bench).
module tb_sram_word_ctrl;
    localparam int A   = 2;
    localparam int AW  = 18;
    localparam int WIN = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_data_in, sram_data_out;
    logic          sram_data_oe, sram_cs_n, sram_oe_n, sram_we_n;

    sram_word_ctrl_if bus ();

    sram_word_ctrl #(.ACCESS_CYCLES(A), .SRAM_ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out),
        .sram_data_oe  (sram_data_oe),
        .sram_cs_n     (sram_cs_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device model (only the preload port and WE_N write into it)
    logic [15:0]   dev [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [15:0]   pre_data = '0;
    assign sram_data_in = dev[sram_addr];
    always @(posedge clk) begin
        if (pre_en) dev[pre_addr] <= pre_data;
        else if (!sram_cs_n && !sram_we_n) dev[sram_addr] <= sram_data_out;
    end

    // reference memory, updated at halfword/byte level from the bus rules
    logic [15:0] ref_m [0:WIN-1];

    // pin monitor
    int ovl_err = 0, doe_err = 0, stab_err = 0;
    int oe_cyc = 0, we_cyc = 0, we_pulse = 0, cs_cyc = 0, rdy_cyc = 0;
    int acc [0:WIN-1];
    logic          prev_we = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    logic [15:0]   prev_d = '0;
    initial for (int i = 0; i < WIN; i++) acc[i] = 0;
    always @(negedge clk) begin
        if (!sram_oe_n && !sram_we_n) ovl_err++;
        if (sram_data_oe && (!sram_oe_n || sram_cs_n)) doe_err++;
        if (!rst && (!sram_we_n || !prev_we) &&
            (sram_addr !== prev_addr || sram_data_out !== prev_d)) stab_err++;
        if (!sram_oe_n) oe_cyc++;
        if (!sram_we_n) we_cyc++;
        if (!sram_we_n && prev_we) we_pulse++;
        if (bus.mem_ready) rdy_cyc++;
        if (!sram_cs_n) begin
            cs_cyc++;
            if (sram_addr < AW'(WIN)) acc[sram_addr]++;
        end
        prev_we = sram_we_n; prev_addr = sram_addr; prev_d = sram_data_out;
    end

    int n_assert = 0, n_fail = 0;
    int s_oe, s_we, s_pulse, s_cs, s_rdy;
    int s_acc [0:WIN-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        s_oe = oe_cyc; s_we = we_cyc; s_pulse = we_pulse;
        s_cs = cs_cyc; s_rdy = rdy_cyc;
        for (int i = 0; i < WIN; i++) s_acc[i] = acc[i];
    endtask

    task automatic load(input int i, input logic [15:0] v);
        ref_m[i] = v;
        pre_addr = AW'(i); pre_data = v; pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    function automatic int hw_base(input logic [31:0] a);
        return int'(((a >> 2) << 1) % (1 << AW));
    endfunction

    function automatic int exp_lat(input logic [3:0] s);
        int c;
        logic [1:0] lo, hi;
        lo = s[1:0]; hi = s[3:2];
        if (s == 4'h0) return 2 * A + 1;
        c = 1;
        if (lo == 2'b11) c += A + 2; else if (lo != 2'b00) c += 2 * A + 2;
        if (hi == 2'b11) c += A + 2; else if (hi != 2'b00) c += 2 * A + 2;
        return c;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int b;
        b = hw_base(a);
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_m[b + i / 2][8 * (i % 2) +: 8] = d[8 * i +: 8];
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat);
        step();
        bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.mem_ready !== 1'b1 && lat < 100);
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a, d, exp_rd, hold;
        logic [3:0]  s;
        logic [15:0] old_lo;
        int lat, b, bad;

        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        for (int i = 0; i < WIN; i++) load(i, 16'($urandom));
        load(2, 16'h5678);
        load(3, 16'h1234);

        // reset held with a pending request
        snap();
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_cs_n", sram_cs_n, 1);
            chk("rst_ready", bus.mem_ready, 0);
        end
        chk("rst_rdata", bus.mem_rdata, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dout", sram_data_out, 0);
        chk("rst_pins", {sram_data_oe, sram_oe_n, sram_we_n}, 3'b011);
        chk("rst_no_strobe", cs_cyc - s_cs, 0);
        bus.mem_valid = 1'b0;
        rst = 1'b0;

        // read of SRAM[3:2]
        snap();
        txn(32'h4, 32'h0, 4'h0, rd, lat);
        chk("rd_data", rd, 32'h12345678);
        chk("rd_lat", lat, 5);
        chk("rd_oe_cyc", oe_cyc - s_oe, 2 * A);
        chk("rd_we_cyc", we_cyc - s_we, 0);
        hold = 32'h12345678;

        // full word write
        snap();
        txn(32'h100, 32'hDEADBEEF, 4'hF, rd, lat);
        ref_write(32'h100, 32'hDEADBEEF, 4'hF);
        chk("fw_lat", lat, 9);
        chk("fw_pulses", we_pulse - s_pulse, 2);
        chk("fw_we_cyc", we_cyc - s_we, 2 * A);
        chk("fw_oe_cyc", oe_cyc - s_oe, 0);
        chk("fw_rdata_kept", rd, hold);
        chk("fw_lo", dev[32'h80], 16'hBEEF);
        chk("fw_hi", dev[32'h81], 16'hDEAD);

        // single-byte RMW into the hi halfword
        snap();
        txn(32'h100, 32'h00AA0000, 4'b0100, rd, lat);
        ref_write(32'h100, 32'h00AA0000, 4'b0100);
        chk("rmw_lat", lat, 7);
        chk("rmw_hi", dev[32'h81], 16'hDEAA);
        chk("rmw_lo", dev[32'h80], 16'hBEEF);
        chk("rmw_lo_untouched", acc[32'h80] - s_acc[32'h80], 0);
        chk("rmw_hi_cs", acc[32'h81] - s_acc[32'h81], 2 * A + 2);
        chk("rmw_pulses", we_pulse - s_pulse, 1);

        // address wrap, lo halfword only
        snap();
        txn(32'h00080004, 32'h00001111, 4'b0011, rd, lat);
        ref_write(32'h00080004, 32'h00001111, 4'b0011);
        chk("wrap_lat", lat, A + 3);
        chk("wrap_lo", dev[2], 16'h1111);
        chk("wrap_hi", dev[3], 16'h1234);
        chk("wrap_cs_at2", acc[2] - s_acc[2], A + 2);
        chk("wrap_cs_total", cs_cyc - s_cs, A + 2);

        // reset during the first write pulse
        old_lo = ref_m[32'h100];
        snap();
        step();
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h200;
        bus.mem_wdata = 32'hCAFEF00D; bus.mem_wstrb = 4'hF;
        step();
        chk("rmid_setup_doe", sram_data_oe, 1);
        step();
        chk("rmid_pulse_we", sram_we_n, 0);
        rst = 1'b1;
        bus.mem_valid = 1'b0;
        step();
        chk("rmid_we_n", sram_we_n, 1);
        chk("rmid_doe", sram_data_oe, 0);
        chk("rmid_cs_n", sram_cs_n, 1);
        chk("rmid_rdata", bus.mem_rdata, 0);
        rst = 1'b0;
        repeat (4) step();
        chk("rmid_no_ready", rdy_cyc - s_rdy, 0);
        chk("rmid_lo_coherent", (dev[32'h100] === old_lo) || (dev[32'h100] === 16'hF00D), 1);
        ref_m[32'h100] = dev[32'h100];
        txn(32'h200, 32'h0, 4'h0, rd, lat);
        chk("rmid_readback", rd, {ref_m[32'h101], ref_m[32'h100]});
        hold = rd;

        // random traffic against the reference memory
        for (int n = 0; n < 60; n++) begin
            a = ($urandom & 32'hFFF80000) | (32'($urandom_range(0, 255)) << 1) | ($urandom & 32'h3);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) s = 4'h0;
            b = hw_base(a);
            exp_rd = (s == 4'h0) ? {ref_m[b + 1], ref_m[b]} : hold;
            txn(a, d, s, rd, lat);
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_lat", n), lat, exp_lat(s));
            if (s != 4'h0) ref_write(a, d, s);
            hold = exp_rd;
        end

        bad = 0;
        for (int i = 0; i < WIN; i++) if (dev[i] !== ref_m[i]) bad++;
        chk("mem_image", bad, 0);
        chk("oe_we_overlap", ovl_err, 0);
        chk("data_oe_outside_wr", doe_err, 0);
        chk("addr_data_stable_we", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
